// File: rtl/cross_bar_rr_if.sv
// rtl/cross_bar_rr_if.sv - req/ack/resp bus bundle for the N x M round-robin crossbar
// Ports (interface signals):
//   m_req/m_addr/m_cmd/m_wdata   master requests into the crossbar
//   m_ack/m_rdata/m_resp         acks and read responses back to masters
//   s_req/s_addr/s_cmd/s_wdata   requests forwarded to slaves
//   s_ack/s_rdata/s_resp         slave accepts and read data
//   err_resp                     sticky per-slave orphan-response flag
// Modports: slave = crossbar view, master = environment (masters + slaves) view.
interface cross_bar_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]        m_cmd;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS*DATA_W-1:0] m_rdata;
  logic [N_MASTERS-1:0]        m_resp;
  logic [N_SLAVES-1:0]         s_req;
  logic [N_SLAVES*ADDR_W-1:0]  s_addr;
  logic [N_SLAVES-1:0]         s_cmd;
  logic [N_SLAVES*DATA_W-1:0]  s_wdata;
  logic [N_SLAVES-1:0]         s_ack;
  logic [N_SLAVES*DATA_W-1:0]  s_rdata;
  logic [N_SLAVES-1:0]         s_resp;
  logic [N_SLAVES-1:0]         err_resp;

  modport slave (
    input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    output m_ack, m_rdata, m_resp, s_req, s_addr, s_cmd, s_wdata, err_resp
  );

  modport master (
    output m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata, s_resp,
    input  m_ack, m_rdata, m_resp, s_req, s_addr, s_cmd, s_wdata, err_resp
  );
endinterface

// File: rtl/cross_bar_rr.sv
// rtl/cross_bar_rr.sv - N-master x M-slave crossbar, round-robin per slave, in-order read return
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      cross_bar_rr_if.slave: master side (m_*), slave side (s_*), err_resp
module cross_bar_rr #(
  parameter int N_MASTERS  = 4,
  parameter int N_SLAVES   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  cross_bar_rr_if.slave bus
);
  localparam int MW    = $clog2(N_MASTERS);
  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int PW    = $clog2(RESP_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e state_q [N_SLAVES];
  state_e state_d [N_SLAVES];
  logic [N_SLAVES-1:0][MW-1:0]                  owner_q, owner_d, rr_q, rr_d;
  logic [N_SLAVES-1:0][RESP_DEPTH-1:0][MW-1:0]  fifo_q, fifo_d;
  logic [N_SLAVES-1:0][PW:0]                    wp_q, wp_d, rp_q, rp_d;
  logic [N_MASTERS-1:0][CW-1:0]                 cnt_q, cnt_d;
  logic [N_MASTERS-1:0][SEL_W-1:0]              oslv_q, oslv_d;
  logic [N_SLAVES-1:0]                          err_q, err_d;

  logic [N_SLAVES-1:0]           full, empty, gv, push, pop;
  logic [N_SLAVES-1:0][MW-1:0]   gidx, head;
  logic [N_SLAVES-1:0]           elig [N_MASTERS];

  logic [N_MASTERS-1:0]          m_ack_c, m_resp_c;
  logic [N_MASTERS*DATA_W-1:0]   m_rdata_c;
  logic [N_SLAVES-1:0]           s_req_c, s_cmd_c;
  logic [N_SLAVES*ADDR_W-1:0]    s_addr_c;
  logic [N_SLAVES*DATA_W-1:0]    s_wdata_c;

  // FIFO status and eligibility. A read is only eligible when the master has
  // no reads in flight elsewhere, so responses to one master never collide.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      empty[j] = (wp_q[j] == rp_q[j]);
      full[j]  = (wp_q[j] == {~rp_q[j][PW], rp_q[j][PW-1:0]});
      head[j]  = fifo_q[j][rp_q[j][PW-1:0]];
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        elig[i][j] = bus.m_req[i]
                  && (bus.m_addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W] == SEL_W'(j))
                  && (bus.m_cmd[i]
                      || (((cnt_q[i] == '0) || (oslv_q[i] == SEL_W'(j))) && !full[j]));
      end
    end
  end

  // Per-slave arbiter FSM: IDLE picks round-robin, LOCKED holds the owner.
  always_comb begin
    for (int j = 0; j < N_SLAVES; j++) begin
      gv[j]      = 1'b0;
      gidx[j]    = '0;
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      rr_d[j]    = rr_q[j];
      if (state_q[j] == LOCKED) begin
        if (elig[owner_q[j]][j]) begin
          gv[j]   = 1'b1;
          gidx[j] = owner_q[j];
        end else begin
          state_d[j] = IDLE;
        end
      end else begin
        // Scan downward so the closest master after rr_q wins (last write wins).
        for (int k = N_MASTERS; k >= 1; k--) begin
          if (elig[(int'(rr_q[j]) + k) % N_MASTERS][j]) begin
            gv[j]   = 1'b1;
            gidx[j] = MW'((int'(rr_q[j]) + k) % N_MASTERS);
          end
        end
      end
      if (!reset_n) gv[j] = 1'b0;
      if (gv[j]) begin
        if (bus.s_ack[j]) begin
          rr_d[j]    = gidx[j];
          state_d[j] = IDLE;
        end else begin
          owner_d[j] = gidx[j];
          state_d[j] = LOCKED;
        end
      end
    end
  end

  // Zero-latency forwarding, acks and response routing.
  always_comb begin
    m_ack_c   = '0;
    m_resp_c  = '0;
    m_rdata_c = '0;
    s_req_c   = '0;
    s_cmd_c   = '0;
    s_addr_c  = '0;
    s_wdata_c = '0;
    for (int j = 0; j < N_SLAVES; j++) begin
      push[j] = gv[j] & bus.s_ack[j] & ~bus.m_cmd[gidx[j]];
      pop[j]  = reset_n & bus.s_resp[j] & ~empty[j];
      if (gv[j]) begin
        s_req_c[j] = 1'b1;
        s_cmd_c[j] = bus.m_cmd[gidx[j]];
        s_addr_c[j*ADDR_W +: ADDR_W]  = bus.m_addr[int'(gidx[j])*ADDR_W +: ADDR_W];
        s_wdata_c[j*DATA_W +: DATA_W] = bus.m_wdata[int'(gidx[j])*DATA_W +: DATA_W];
        if (bus.s_ack[j]) m_ack_c[gidx[j]] = 1'b1;
      end
      if (pop[j]) begin
        m_resp_c[head[j]] = 1'b1;
        m_rdata_c[int'(head[j])*DATA_W +: DATA_W] = bus.s_rdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // ID FIFOs, outstanding-read bookkeeping and the orphan-response flag.
  always_comb begin
    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    oslv_d = oslv_q;
    for (int j = 0; j < N_SLAVES; j++) begin
      if (push[j]) begin
        fifo_d[j][wp_q[j][PW-1:0]] = gidx[j];
        wp_d[j] = wp_q[j] + 1'b1;
      end
      if (pop[j]) rp_d[j] = rp_q[j] + 1'b1;
      if (bus.s_resp[j] && empty[j]) err_d[j] = 1'b1;
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      for (int j = 0; j < N_SLAVES; j++) begin
        if (push[j] && (gidx[j] == MW'(i))) begin
          cnt_d[i]  = cnt_d[i] + 1'b1;
          oslv_d[i] = SEL_W'(j);
        end
        if (pop[j] && (head[j] == MW'(i))) cnt_d[i] = cnt_d[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '{default: IDLE};
      owner_q <= '0;
      rr_q    <= {N_SLAVES{MW'(N_MASTERS - 1)}};
      fifo_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      oslv_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      fifo_q  <= fifo_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      oslv_q  <= oslv_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_ack    = m_ack_c;
  assign bus.m_resp   = m_resp_c;
  assign bus.m_rdata  = m_rdata_c;
  assign bus.s_req    = s_req_c;
  assign bus.s_cmd    = s_cmd_c;
  assign bus.s_addr   = s_addr_c;
  assign bus.s_wdata  = s_wdata_c;
  assign bus.err_resp = err_q;
endmodule

// File: tb/tb_cross_bar_rr.sv
// tb/tb_cross_bar_rr.sv - directed and randomized bench for cross_bar_rr against a queue-based model
module tb_cross_bar_rr;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cross_bar_rr_if #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cross_bar_rr #(
    .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: per-slave rr pointer, lock owner (-1 = none), queue of reader IDs.
  int rr [NS];
  int lock [NS];
  int q [NS][$];
  bit merr [NS];
  int ocnt [NM];
  int oslv [NM];
  logic [NM-1:0] mdl_ack = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < NS; j++) begin
      rr[j] = NM - 1;
      lock[j] = -1;
      q[j].delete();
      merr[j] = 1'b0;
    end
    for (int i = 0; i < NM; i++) begin
      ocnt[i] = 0;
      oslv[i] = 0;
    end
  endfunction

  function automatic bit can_go(int i, int j);
    logic [AW-1:0] a;
    a = bus.m_addr[i*AW +: AW];
    if (!bus.m_req[i] || int'(a >> (AW - 2)) != j) return 1'b0;
    if (bus.m_cmd[i]) return 1'b1;
    return (ocnt[i] == 0 || oslv[i] == j) && (q[j].size() < RD);
  endfunction

  always @(negedge clk) begin : cmp_p
    logic [NM-1:0]    e_ack, e_resp;
    logic [NM*DW-1:0] e_rd;
    logic [NS-1:0]    e_req, e_cmd, e_err;
    logic [NS*AW-1:0] e_addr;
    logic [NS*DW-1:0] e_wd;
    int win [NS];
    int c;
    int h;
    e_ack = '0; e_resp = '0; e_rd = '0; e_req = '0; e_cmd = '0;
    e_addr = '0; e_wd = '0; e_err = '0;
    for (int j = 0; j < NS; j++) win[j] = -1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int j = 0; j < NS; j++) begin
        e_err[j] = merr[j];
        if (lock[j] >= 0) begin
          if (can_go(lock[j], j)) win[j] = lock[j];
        end else begin
          for (int k = 1; k <= NM; k++) begin
            c = (rr[j] + k) % NM;
            if (win[j] < 0 && can_go(c, j)) win[j] = c;
          end
        end
        if (win[j] >= 0) begin
          e_req[j] = 1'b1;
          e_cmd[j] = bus.m_cmd[win[j]];
          e_addr[j*AW +: AW] = bus.m_addr[win[j]*AW +: AW];
          e_wd[j*DW +: DW]   = bus.m_wdata[win[j]*DW +: DW];
          if (bus.s_ack[j]) e_ack[win[j]] = 1'b1;
        end
        if (bus.s_resp[j] && q[j].size() > 0) begin
          e_resp[q[j][0]] = 1'b1;
          e_rd[q[j][0]*DW +: DW] = bus.s_rdata[j*DW +: DW];
        end
      end
    end
    chk("m_ack", bus.m_ack, e_ack);
    chk("m_resp", bus.m_resp, e_resp);
    chk("m_rdata", bus.m_rdata, e_rd);
    chk("s_req", bus.s_req, e_req);
    chk("s_cmd", bus.s_cmd, e_cmd);
    chk("s_addr", bus.s_addr, e_addr);
    chk("s_wdata", bus.s_wdata, e_wd);
    chk("err_resp", bus.err_resp, e_err);
    mdl_ack = e_ack;
    if (rst_n) begin
      for (int j = 0; j < NS; j++) begin
        if (bus.s_resp[j]) begin
          if (q[j].size() > 0) begin
            h = q[j].pop_front();
            ocnt[h]--;
          end else begin
            merr[j] = 1'b1;
          end
        end
      end
      for (int j = 0; j < NS; j++) begin
        if (win[j] >= 0) begin
          if (bus.s_ack[j]) begin
            if (!bus.m_cmd[win[j]]) begin
              q[j].push_back(win[j]);
              ocnt[win[j]]++;
              oslv[win[j]] = j;
            end
            rr[j] = win[j];
            lock[j] = -1;
          end else begin
            lock[j] = win[j];
          end
        end else begin
          lock[j] = -1;
        end
      end
    end
  end

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_req = '0;
    bus.s_ack = '0;
    bus.s_resp = '0;
  endtask

  task automatic setm(input int i, input logic [AW-1:0] a, input logic c, input logic [DW-1:0] d);
    bus.m_req[i] = 1'b1;
    bus.m_addr[i*AW +: AW] = a;
    bus.m_cmd[i] = c;
    bus.m_wdata[i*DW +: DW] = d;
  endtask

  logic [NM-1:0] exp2 [6];
  bit pend [NM];

  initial begin
    bus.m_req = '0; bus.m_addr = '0; bus.m_cmd = '0; bus.m_wdata = '0;
    bus.s_ack = '0; bus.s_rdata = '0; bus.s_resp = '0;
    exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < NM; i++) pend[i] = 1'b0;

    // Reset holds every output low even with live requests.
    setm(0, 32'h4000_0010, 1'b1, 32'hA5);
    bus.s_ack = 4'b1111;
    mid();
    chk("rst_s_req", bus.s_req, 0);
    chk("rst_m_ack", bus.m_ack, 0);
    chk("rst_err", bus.err_resp, 0);
    nxt();
    rst_n = 1'b1;

    // Single write to slave 1, acked the same cycle.
    idle();
    setm(0, 32'h4000_0010, 1'b1, 32'hA5);
    bus.s_ack = 4'b0010;
    mid();
    chk("wr_s_req", bus.s_req, 4'b0010);
    chk("wr_s_addr", bus.s_addr[1*AW +: AW], 32'h4000_0010);
    chk("wr_s_wdata", bus.s_wdata[1*DW +: DW], 32'hA5);
    chk("wr_m_ack", bus.m_ack, 4'b0001);
    nxt();

    // Three masters hammer slave 0: round-robin order from master 0.
    idle();
    for (int i = 0; i < 3; i++) setm(i, 32'h0000_0040 * (i + 1), 1'b1, 32'(i));
    bus.s_ack = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      mid();
      chk($sformatf("rr_order%0d", c), bus.m_ack, exp2[c]);
      nxt();
    end

    // Lock: M3 read on slave 2 held through 3 un-acked cycles, then M1.
    idle();
    setm(3, 32'h8000_0030, 1'b0, 32'h0);
    mid();
    chk("lock_addr0", bus.s_addr[2*AW +: AW], 32'h8000_0030);
    nxt();
    setm(1, 32'h8000_0044, 1'b1, 32'h11);
    for (int c = 1; c < 3; c++) begin
      mid();
      chk($sformatf("lock_addr%0d", c), bus.s_addr[2*AW +: AW], 32'h8000_0030);
      chk($sformatf("lock_noack%0d", c), bus.m_ack, 0);
      nxt();
    end
    bus.s_ack = 4'b0100;
    mid();
    chk("lock_ack_m3", bus.m_ack, 4'b1000);
    nxt();
    bus.m_req[3] = 1'b0;
    mid();
    chk("lock_next_addr", bus.s_addr[2*AW +: AW], 32'h8000_0044);
    chk("lock_ack_m1", bus.m_ack, 4'b0010);
    nxt();
    idle();
    bus.s_resp = 4'b0100;
    bus.s_rdata[2*DW +: DW] = 32'h77;
    mid();
    chk("lock_resp", bus.m_resp, 4'b1000);
    chk("lock_rdata", bus.m_rdata[3*DW +: DW], 32'h77);
    nxt();

    // FIFO full: 4 reads to slave 3, 5th held until a response drains one.
    idle();
    setm(0, 32'hC000_0000, 1'b0, 32'h0);
    bus.s_ack = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("full_ack%0d", c), bus.m_ack, 4'b0001);
      nxt();
    end
    mid();
    chk("full_held", bus.s_req, 0);
    nxt();
    bus.s_resp = 4'b1000;
    bus.s_rdata[3*DW +: DW] = 32'h1234;
    mid();
    chk("full_resp", bus.m_resp, 4'b0001);
    chk("full_rdata", bus.m_rdata[0 +: DW], 32'h1234);
    chk("full_still_held", bus.s_req, 0);
    nxt();
    bus.s_resp = '0;
    mid();
    chk("full_5th_req", bus.s_req, 4'b1000);
    chk("full_5th_ack", bus.m_ack, 4'b0001);
    nxt();
    idle();
    bus.s_resp = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      bus.s_rdata[3*DW +: DW] = 32'(c + 1);
      mid();
      chk($sformatf("drain%0d", c), bus.m_resp, 4'b0001);
      nxt();
    end

    // One slave at a time for reads; writes are not blocked.
    idle();
    setm(0, 32'h0000_0008, 1'b0, 32'h0);
    bus.s_ack = 4'b0001;
    nxt();
    idle();
    setm(0, 32'h4000_0008, 1'b0, 32'h0);
    bus.s_ack = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk($sformatf("xs_block%0d", c), bus.s_req, 0);
      nxt();
    end
    bus.s_resp = 4'b0001;
    bus.s_rdata[0 +: DW] = 32'hBEEF;
    mid();
    chk("xs_resp", bus.m_resp, 4'b0001);
    chk("xs_block_resp_cycle", bus.s_req, 0);
    nxt();
    bus.s_resp = '0;
    mid();
    chk("xs_unblock", bus.s_req, 4'b0010);
    nxt();
    idle();
    bus.s_resp = 4'b0010;
    nxt();
    idle();
    setm(0, 32'h0000_0010, 1'b0, 32'h0);
    bus.s_ack = 4'b0001;
    nxt();
    idle();
    setm(0, 32'h4000_0010, 1'b1, 32'h99);
    bus.s_ack = 4'b0010;
    mid();
    chk("xs_write_go", bus.s_req, 4'b0010);
    chk("xs_write_ack", bus.m_ack, 4'b0001);
    nxt();
    idle();
    bus.s_resp = 4'b0001;
    nxt();

    // Orphan response on idle slave 2.
    idle();
    bus.s_resp = 4'b0100;
    mid();
    chk("orphan_no_resp", bus.m_resp, 0);
    nxt();
    bus.s_resp = '0;
    mid();
    chk("orphan_err", bus.err_resp, 4'b0100);
    nxt();

    // Randomized traffic; masters hold each request until the model says acked.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (pend[i] && mdl_ack[i]) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(0, 99) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          setm(i, {2'($urandom_range(0, NS - 1)), 30'($urandom)}, 1'($urandom), $urandom);
        end
        bus.m_req[i] = pend[i];
      end
      bus.s_ack = 4'($urandom);
      for (int j = 0; j < NS; j++) begin
        bus.s_resp[j] = ($urandom_range(0, 3) == 0);
        bus.s_rdata[j*DW +: DW] = $urandom;
      end
      nxt();
    end

    // Reset in the middle of live traffic.
    rst_n = 1'b0;
    mid();
    chk("mid_rst_s_req", bus.s_req, 0);
    chk("mid_rst_m_ack", bus.m_ack, 0);
    chk("mid_rst_m_resp", bus.m_resp, 0);
    chk("mid_rst_s_addr", bus.s_addr, 0);
    chk("mid_rst_err", bus.err_resp, 0);
    nxt();
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) nxt();
    mid();
    chk("post_rst_err", bus.err_resp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
